// File: rtl/xoodyak_pkg.sv
// xoodyak_pkg: constants, FSM state type and helpers shared by the message
// loader and the XOODYAK hash core.
package xoodyak_pkg;

  // Message length / RAM address width and datapath byte width.
  localparam int LEN_W  = 12;
  localparam int BYTE_W = 8;

  // Loader defaults.
  localparam int DEF_MAX_LEN        = 1024;
  localparam int DEF_GAP_CYCLES     = 5;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Hash-interface constants shared with the XOODYAK core.
  localparam int XOODOO_STATE_W  = 384;
  localparam int HASH_W          = 256;
  localparam int HASH_RATE_BYTES = 16;

  // Loader FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_GAP,
    S_START,
    S_WAIT,
    S_DONE
  } loader_state_t;

  // Width of a counter that must reach the larger of two cycle counts.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/xoodyak_msg_loader_if.sv
// xoodyak_msg_loader_if: host request, message RAM and XOODYAK core signals
// of the message loader. master = loader side, slave = environment side.
interface xoodyak_msg_loader_if
  import xoodyak_pkg::*;
#(
  parameter int LEN_W = xoodyak_pkg::LEN_W
);

  // Host request / status.
  logic              req;
  logic [LEN_W-1:0]  req_len;
  logic              busy;
  logic              done;
  logic              err;
  logic              timeout;

  // Message RAM read port.
  logic              mem_rd_en;
  logic [LEN_W-1:0]  mem_addr;
  logic [BYTE_W-1:0] mem_rd_data;

  // XOODYAK core load/start/valid.
  logic              load;
  logic [BYTE_W-1:0] msg;
  logic [LEN_W-1:0]  msg_len;
  logic              start;
  logic              hash_valid;

  modport master (
    input  req, req_len, mem_rd_data, hash_valid,
    output busy, done, err, timeout, mem_rd_en, mem_addr,
           load, msg, msg_len, start
  );

  modport slave (
    output req, req_len, mem_rd_data, hash_valid,
    input  busy, done, err, timeout, mem_rd_en, mem_addr,
           load, msg, msg_len, start
  );

endinterface

// File: rtl/xoodyak_rd_pipe.sv
// xoodyak_rd_pipe: aligns RAM reads with the load/msg outputs. A read strobed
// in cycle c returns data in c+1, which is registered onto msg with load=1
// in c+2. msg holds its last byte when no read is in flight.
module xoodyak_rd_pipe
  import xoodyak_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rd_en,
  input  logic [BYTE_W-1:0] i_rd_data,
  output logic              o_load,
  output logic [BYTE_W-1:0] o_msg
);

  logic              r_rd_valid;
  logic              r_load;
  logic [BYTE_W-1:0] r_msg;

  // Delay the read strobe to the data-return cycle, then register byte and load.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_load     <= 1'b0;
      r_msg      <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      r_load     <= r_rd_valid;
      if (r_rd_valid) r_msg <= i_rd_data;
    end
  end

  assign o_load = r_load;
  assign o_msg  = r_msg;

endmodule

// File: rtl/xoodyak_msg_loader.sv
// xoodyak_msg_loader: streams a message from a byte-wide, 1-cycle-latency RAM
// onto the XOODYAK load/msg/msg_len port, waits a fixed idle gap, pulses
// start and waits for the core's valid before reporting done.
// Optional feature: define XOODYAK_LOADER_TIMEOUT_EN to bound the wait for
// valid to TIMEOUT_CYCLES after start; otherwise the wait is unbounded and
// timeout is constant 0.
module xoodyak_msg_loader
  import xoodyak_pkg::*;
#(
  parameter int LEN_W          = xoodyak_pkg::LEN_W,
  parameter int MAX_LEN        = DEF_MAX_LEN,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  xoodyak_msg_loader_if.master bus
);

  // One counter serves DRAIN, GAP and (optionally) WAIT.
  localparam int                CNT_W      = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [LEN_W-1:0]  MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  loader_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [LEN_W-1:0] r_msg_len, w_msg_len_nxt;
  logic             r_mem_rd_en, w_mem_rd_en_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_start, w_start_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic w_req_big;
  logic w_req_empty;
  logic w_fetch_last;
  logic w_wait_expired;

  assign w_req_big    = (bus.req_len > MAX_LEN_L);
  assign w_req_empty  = (bus.req_len == '0);
  assign w_fetch_last = (r_mem_addr == r_msg_len - 1'b1);

`ifdef XOODYAK_LOADER_TIMEOUT_EN
  // The WAIT counter is loaded with 1 on entry, so it equals the number of
  // cycles since the start pulse; expiring at TIMEOUT_CYCLES-1 puts done
  // exactly TIMEOUT_CYCLES cycles after start.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  assign w_wait_expired = (r_cnt == WAIT_LAST);
`else
  assign w_wait_expired = 1'b0;
`endif

  // State register, counter and registered outputs; all clear asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_msg_len   <= '0;
      r_mem_rd_en <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_msg_len   <= w_msg_len_nxt;
      r_mem_rd_en <= w_mem_rd_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_start     <= w_start_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Next-state decode.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.req && !w_req_big) w_state_nxt = w_req_empty ? S_GAP : S_FETCH;
      S_FETCH: if (w_fetch_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_cnt == DRAIN_LAST) w_state_nxt = S_GAP;
      S_GAP:   if (r_cnt == GAP_LAST) w_state_nxt = S_START;
      // valid seen during the start cycle belongs to no request and is ignored
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.hash_valid || w_wait_expired) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, address and counter.
  always_comb begin
    w_cnt_nxt       = '0;
    w_mem_addr_nxt  = r_mem_addr;
    w_msg_len_nxt   = r_msg_len;
    w_mem_rd_en_nxt = 1'b0;
    w_err_nxt       = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_start_nxt     = (w_state_nxt == S_START);
    w_done_nxt      = (w_state_nxt == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (w_req_big) begin
            w_err_nxt = 1'b1;
          end else begin
            // first read goes out in the first FETCH cycle
            w_msg_len_nxt   = bus.req_len;
            w_mem_addr_nxt  = '0;
            w_mem_rd_en_nxt = !w_req_empty;
          end
        end
      end
      S_FETCH: begin
        // address holds at len-1 after the last read: never runs past the message
        if (!w_fetch_last) begin
          w_mem_addr_nxt  = r_mem_addr + 1'b1;
          w_mem_rd_en_nxt = 1'b1;
        end
      end
      S_DRAIN, S_GAP: begin
        if (w_state_nxt == r_state) w_cnt_nxt = r_cnt + 1'b1;
      end
`ifdef XOODYAK_LOADER_TIMEOUT_EN
      S_START: w_cnt_nxt = CNT_W'(1);
      S_WAIT: begin
        if (w_state_nxt == S_WAIT) w_cnt_nxt = r_cnt + 1'b1;
        w_timeout_nxt = w_wait_expired && !bus.hash_valid;
      end
`endif
      default: ;
    endcase
  end

  xoodyak_rd_pipe u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .i_rd_en   (r_mem_rd_en),
    .i_rd_data (bus.mem_rd_data),
    .o_load    (bus.load),
    .o_msg     (bus.msg)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.timeout   = r_timeout;
  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.msg_len   = r_msg_len;
  assign bus.start     = r_start;

endmodule

// File: tb/tb_xoodyak_msg_loader.sv
// tb_xoodyak_msg_loader: table-driven checks of the message loader plus hand
// sequences for mid-burst reset and (with XOODYAK_LOADER_TIMEOUT_EN) timeout.
module tb_xoodyak_msg_loader;

`ifdef XOODYAK_LOADER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 4096;
`endif
  localparam int START_WAIT = 3000;

  typedef struct {
    int         len;
    int         hv_delay;      // cycles after the first WAIT cycle before valid
    int         dup_at;        // cycles after accept for a stray req (0 = none)
    bit         exp_err;
    int         exp_start_off; // start cycle minus req cycle
    logic [7:0] exp_last;      // last byte presented on msg
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_err;

  xoodyak_msg_loader_if #(.LEN_W(12)) bus ();

  xoodyak_msg_loader #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Byte RAM, 1-cycle read latency, RAM[i] = i mod 256.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: statistics sampled on the falling edge.
  bit         clr_req;
  int         exp_len;
  int         load_cnt, load_rise, rd_cnt, max_addr, byte_bad, msglen_bad;
  int         start_cnt, done_cnt, err_cnt, busy_cnt, to_cnt, to_bad;
  int         last_load_cyc, done_cyc, err_cyc;
  logic [7:0] last_msg;
  logic       prev_load;

  always @(negedge clk) begin
    if (clr_req) begin
      load_cnt <= 0; load_rise <= 0; rd_cnt <= 0; max_addr <= 0;
      byte_bad <= 0; msglen_bad <= 0; start_cnt <= 0; done_cnt <= 0;
      err_cnt <= 0; busy_cnt <= 0; to_cnt <= 0; to_bad <= 0;
      last_load_cyc <= 0; done_cyc <= 0; err_cyc <= 0;
      last_msg <= '0; prev_load <= 1'b0;
    end else begin
      prev_load <= bus.load;
      if (bus.load) begin
        load_cnt      <= load_cnt + 1;
        last_msg      <= bus.msg;
        last_load_cyc <= cyc;
        if (bus.msg !== 8'(load_cnt)) byte_bad <= byte_bad + 1;
        if (!prev_load) load_rise <= load_rise + 1;
      end
      if (bus.mem_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (int'(bus.mem_addr) > max_addr) max_addr <= int'(bus.mem_addr);
      end
      if (bus.busy) begin
        busy_cnt <= busy_cnt + 1;
        if (bus.msg_len !== 12'(exp_len)) msglen_bad <= msglen_bad + 1;
      end
      if (bus.start) start_cnt <= start_cnt + 1;
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        if (bus.timeout) to_cnt <= to_cnt + 1;
      end
      if (bus.timeout && !bus.done) to_bad <= to_bad + 1;
      if (bus.err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic issue_req(input int len, output int req_cyc);
    @(posedge clk);
    #1;
    bus.req     = 1'b1;
    bus.req_len = 12'(len);
    req_cyc     = cyc;
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  task automatic wait_start(output bit got, output int s_cyc);
    got   = 1'b0;
    s_cyc = 0;
    for (int k = 0; k < START_WAIT && !got; k++) begin
      @(negedge clk);
      if (bus.start) begin
        got   = 1'b1;
        s_cyc = cyc;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int req_cyc, s_cyc;
    bit got;
    clear_stats();
    exp_len = v.len;
    issue_req(v.len, req_cyc);
    if (v.dup_at > 0) begin
      repeat (v.dup_at - 1) @(posedge clk);
      #1;
      bus.req     = 1'b1;
      bus.req_len = 12'd1025;
      @(posedge clk);
      #1 bus.req = 1'b0;
    end
    if (v.exp_err) begin
      repeat (10) @(negedge clk);
      check("err_pulses", err_cnt, 1);
      check("err_cycle", err_cyc - req_cyc, 1);
      check("err_busy_cycles", busy_cnt, 0);
      check("err_ram_reads", rd_cnt, 0);
      check("err_start", start_cnt, 0);
      return;
    end
    wait_start(got, s_cyc);
    check("start_seen", got, 1);
    if (!got) return;
    check("start_offset", s_cyc - req_cyc, v.exp_start_off);
    // valid during the start cycle must be ignored
    bus.hash_valid = 1'b1;
    @(negedge clk);
    bus.hash_valid = 1'b0;
    repeat (v.hv_delay) @(negedge clk);
    bus.hash_valid = 1'b1;
    @(negedge clk);
    bus.hash_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("done_after_start", done_cyc - s_cyc, 2 + v.hv_delay);
    check("busy_cycles", busy_cnt, done_cyc - req_cyc);
    check("busy_low_after", bus.busy, 0);
    check("timeout_low", to_cnt + to_bad, 0);
    check("err_none", err_cnt, 0);
    check("start_pulses", start_cnt, 1);
    check("load_cycles", load_cnt, v.len);
    check("ram_reads", rd_cnt, v.len);
    check("msg_len_stable", msglen_bad, 0);
    if (v.len > 0) begin
      check("load_contiguous", load_rise, 1);
      check("byte_order", byte_bad, 0);
      check("last_msg", last_msg, v.exp_last);
      check("max_addr", max_addr, v.len - 1);
      check("gap_to_start", s_cyc - last_load_cyc, 6);
    end
  endtask

  vec_t vecs [8];

  initial begin
    int   req_cyc, s_cyc;
    bit   got;

    vecs[0] = '{19,   3, 0, 1'b0, 27,   8'h12};
    vecs[1] = '{1024, 0, 0, 1'b0, 1032, 8'hFF};
    vecs[2] = '{0,    2, 0, 1'b0, 6,    8'h00};
    vecs[3] = '{1025, 0, 0, 1'b1, 0,    8'h00};
    vecs[4] = '{1,    1, 0, 1'b0, 9,    8'h00};
    vecs[5] = '{2,    0, 0, 1'b0, 10,   8'h01};
    vecs[6] = '{19,   4, 5, 1'b0, 27,   8'h12};
    vecs[7] = '{4095, 0, 0, 1'b1, 0,    8'h00};

    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);

    n_checks       = 0;
    n_err          = 0;
    clr_req        = 1'b1;
    exp_len        = 0;
    reset          = 1'b1;
    bus.req        = 1'b0;
    bus.req_len    = '0;
    bus.hash_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_load", bus.load, 0);
    check("rst_start", bus.start, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_flags", {bus.done, bus.err, bus.timeout}, 0);
    check("rst_addr_msg_len", {bus.mem_addr, bus.msg, bus.msg_len}, 0);
    @(negedge clk);
    reset   = 1'b0;
    clr_req = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset asserted at byte 500 of a 1024-byte burst.
    clear_stats();
    exp_len = 1024;
    issue_req(1024, req_cyc);
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      #1;
      if (load_cnt >= 500) got = 1'b1;
    end
    check("rst_reach_byte_500", got, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_load", bus.load, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_rd_en", bus.mem_rd_en, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    repeat (20) @(negedge clk);
    check("rst_no_start", start_cnt, 0);
    check("rst_no_load", load_cnt, 0);
    check("rst_no_reads", rd_cnt, 0);
    run_vec(vecs[0]);

`ifdef XOODYAK_LOADER_TIMEOUT_EN
    // Valid never arrives: done and timeout together TB_TIMEOUT after start.
    clear_stats();
    exp_len = 3;
    issue_req(3, req_cyc);
    wait_start(got, s_cyc);
    check("to_start_seen", got, 1);
    repeat (30) @(negedge clk);
    check("to_done_pulses", done_cnt, 1);
    check("to_done_after_start", done_cyc - s_cyc, TB_TIMEOUT);
    check("to_with_done", to_cnt, 1);
    check("to_without_done", to_bad, 0);
    bus.hash_valid = 1'b1;
    @(negedge clk);
    bus.hash_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("to_late_valid_ignored", done_cnt, 1);
    check("to_idle_busy", bus.busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
